// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scanner and other round-robin users.
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

  // Default configuration: 8 channels, select held 4 cycles before sampling.
  localparam int DEF_N_CH  = 8;
  localparam int DEF_DWELL = 4;
  localparam int SEL_W     = $clog2(DEF_N_CH);
  localparam int CNT_W     = $clog2(DEF_DWELL + 1);

  // First set bit of mask at last+1, last+2, ..., last+N (mod N).
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] last,
                                               input logic [DEF_N_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    rr_next = last;
    for (int i = DEF_N_CH; i >= 1; i--) begin
      idx = SEL_W'(int'(last) + i);
      if (mask[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/mux_scanner_rr_next_finder.sv
// Combinational round-robin priority search: next enabled channel after last.
module rr_next_finder
  import mux_scan_pkg::*;
#(
  parameter int N = 8,
  localparam int SEL_BITS = $clog2(N)
)(
  input  logic [SEL_BITS-1:0] last,
  input  logic [N-1:0]        mask,
  output logic [SEL_BITS-1:0] next,
  output logic                found
);

  // Scan downward so the closest channel after last overwrites farther ones;
  // i == N wraps back to last itself, so a lone enabled last is re-selected.
  always_comb begin
    logic [SEL_BITS-1:0] idx;
    next  = last;
    found = |mask;
    for (int i = N; i >= 1; i--) begin
      idx = SEL_BITS'(int'(last) + i);
      if (mask[idx]) next = idx;
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Round-robin select sequencer and capture stage for an N_CH:1 channel mux.
module mux_scanner
  import mux_scan_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 4,
  parameter int DWELL  = 4,
  localparam int SEL_BITS = $clog2(N_CH),
  localparam int CNT_BITS = $clog2(DWELL + 1)
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [N_CH-1:0]     ch_mask,
  output logic [SEL_BITS-1:0] sel,
  input  logic [DATA_W-1:0]   mux_data,
  input  logic [SEL_BITS-1:0] mux_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_BITS-1:0] out_id,
  output logic                id_err,
  input  logic                err_clr,
  output logic                busy
);

  if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
    $error("mux_scanner: DWELL must be in 1..15");
  end
  if (N_CH < 2 || (1 << SEL_BITS) != N_CH) begin : g_bad_nch
    $error("mux_scanner: N_CH must be a power of two >= 2");
  end

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [SEL_BITS-1:0] last_q, last_d;
  logic [SEL_BITS-1:0] sel_d;
  logic                valid_d;
  logic [DATA_W-1:0]   data_d;
  logic [SEL_BITS-1:0] id_d;
  logic                err_d;
  logic [SEL_BITS-1:0] nxt;
  logic                found;
  logic                start;

  rr_next_finder #(.N(N_CH)) u_rr (
    .last  (last_q),
    .mask  (ch_mask),
    .next  (nxt),
    .found (found)
  );

  assign start = enable && found;
  assign busy  = (state_q != IDLE);

  // Next-state and datapath updates; every register holds unless changed here.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel;
    valid_d = out_valid;
    data_d  = out_data;
    id_d    = out_id;
    err_d   = id_err;
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          sel_d   = nxt;
          last_d  = nxt;
          cnt_d   = CNT_BITS'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_BITS'(DWELL)) begin
          data_d  = mux_data;
          id_d    = mux_id;
          valid_d = 1'b1;
          state_d = PRESENT;
          // A mismatch set takes priority over a simultaneous clear.
          if (mux_id != sel) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = SETTLE;
            sel_d   = nxt;
            last_d  = nxt;
            cnt_d   = CNT_BITS'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; last starts at N_CH-1 so the first search lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_BITS'(N_CH - 1);
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      id_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel       <= sel_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_id    <= id_d;
      id_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner with an ideal mux model and an expected-channel queue.
module tb_mux_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] ch_mask;
  logic [2:0] sel;
  logic [3:0] mux_data;
  logic [2:0] mux_id;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_id;
  logic       id_err;
  logic       err_clr;
  logic       busy;

  logic       force_en;
  logic [2:0] force_id;
  logic [3:0] src [8];

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         exp_q [$];
  bit         track = 1'b0;
  logic [7:0] seen = '0;

  mux_scanner #(.N_CH(8), .DATA_W(4), .DWELL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ch_mask   (ch_mask),
    .sel       (sel),
    .mux_data  (mux_data),
    .mux_id    (mux_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .id_err    (id_err),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal mux: data follows the select, ID echoes it unless a fault is forced.
  assign mux_data = src[sel];
  assign mux_id   = force_en ? force_id : sel;

  always @(negedge clk) if (track) seen <= seen | (8'd1 << sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  // Wait for a sample, compare it to the queue head, then let the handshake edge pass.
  task automatic take(input string tag, input bit stop_after, output int t_seen);
    int ch;
    wait_valid(tag);
    t_seen = cyc;
    chk({tag, "_qnonempty"}, 32'(exp_q.size() > 0), 1);
    ch = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    chk({tag, "_id"},   32'(out_id),   32'(ch));
    chk({tag, "_data"}, 32'(out_data), 32'(src[ch]));
    chk({tag, "_sel"},  32'(sel),      32'(ch));
    if (stop_after) enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t, tprev;
    logic [3:0] d0;
    logic [2:0] i0, s0;
    bit stable;

    for (int i = 0; i < 8; i++) src[i] = 4'(i * 5 + 3);
    rst_n = 1'b0; enable = 1'b0; ch_mask = 8'hFF; out_ready = 1'b1;
    err_clr = 1'b0; force_en = 1'b0; force_id = 3'd0;

    // Reset state
    @(negedge clk);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_err", 32'(id_err), 0);
    chk("rst_busy", 32'(busy), 0);

    // Full mask round robin, one sample every DWELL+1 cycles
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    tprev = 0;
    for (int k = 0; k < 9; k++) begin
      take("rr", k == 8, t);
      if (k > 0) chk("rr_period", 32'(t - tprev), 5);
      tprev = t;
    end
    chk("rr_idle_busy", 32'(busy), 0);

    // Sparse mask: 2,5,7,2 with other channels never selected
    ch_mask = 8'hA4; enable = 1'b1; seen = '0;
    exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(2);
    @(negedge clk);
    track = 1'b1;
    for (int k = 0; k < 4; k++) take("sparse", k == 3, t);
    track = 1'b0;
    @(negedge clk);
    chk("sparse_seen", 32'(seen), 32'h0A4);

    // Backpressure: outputs and select frozen while out_ready is low
    ch_mask = 8'hFF; out_ready = 1'b0; enable = 1'b1;
    exp_q.push_back(3);
    wait_valid("bp");
    d0 = out_data; i0 = out_id; s0 = sel; stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || out_id !== i0 || sel !== s0) stable = 1'b0;
    end
    chk("bp_frozen", 32'(stable), 1);
    out_ready = 1'b1;
    take("bp", 1, t);
    chk("bp_single", 32'(out_valid), 0);
    chk("bp_busy", 32'(busy), 0);

    // ID mismatch sets the sticky flag; a simultaneous clear loses to the set
    ch_mask = 8'h20; force_en = 1'b1; force_id = 3'd3; enable = 1'b1;
    wait_valid("err1");
    chk("err1_id", 32'(out_id), 3);
    chk("err1_sel", 32'(sel), 5);
    chk("err1_flag", 32'(id_err), 1);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_sticky", 32'(id_err), 1);
    err_clr = 1'b1; enable = 1'b1;
    @(negedge clk);
    chk("err_cleared_early", 32'(id_err), 0);
    wait_valid("err2");
    err_clr = 1'b0;
    chk("err_set_wins", 32'(id_err), 1);
    chk("err2_sel", 32'(sel), 5);
    enable = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_alone", 32'(id_err), 0);
    force_en = 1'b0;

    // Enable dropped during SETTLE on channel 4, then re-selected alone
    ch_mask = 8'h10; enable = 1'b1;
    exp_q.push_back(4);
    @(negedge clk);
    chk("drop_busy", 32'(busy), 1);
    enable = 1'b0;
    take("drop", 0, t);
    chk("drop_idle", 32'(busy), 0);
    chk("drop_sel", 32'(sel), 4);
    enable = 1'b1;
    exp_q.push_back(4);
    take("reen", 1, t);
    chk("reen_sel", 32'(sel), 4);

    // Asynchronous reset in the middle of a stalled PRESENT
    ch_mask = 8'hFF; out_ready = 1'b0; force_en = 1'b1; force_id = 3'd0; enable = 1'b1;
    wait_valid("arst");
    chk("arst_pre_sel", 32'(sel), 5);
    chk("arst_pre_err", 32'(id_err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_err", 32'(id_err), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_data", 32'(out_data), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
